// File: rtl/meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and default sizing.
package meter_pkg;

    typedef enum logic [1:0] {
        WARMUP    = 2'd0,
        IDLE      = 2'd1,
        WAIT_EDGE = 2'd2,
        MEASURE   = 2'd3
    } meter_state_t;

    localparam int unsigned DEFAULT_CNT_W       = 32;
    localparam int unsigned DEFAULT_TIMEOUT     = 25_000_000;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    // 100 MHz system clock divided down to 10 Hz
    localparam int unsigned EXPECTED_10HZ_PERIOD = 10_000_000;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the clk domain and flags its rising edges.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // NOTE: non-blocking assignments let every stage sample the value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], sig_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// single-shot or continuous, with a no-edge timeout.
module clk_period_meter
    import meter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             period_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             timeout
);

    localparam int unsigned      WARM_W      = $clog2(SYNC_STAGES + 1);
    localparam logic [WARM_W-1:0] WARM_LAST  = WARM_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  TIMER_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    logic sync;
    logic rise;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .sync   (sync),
        .rise   (rise)
    );

    meter_state_t      state, state_nx;
    logic [WARM_W-1:0] warm_cnt, warm_nx;
    logic              cont_r, cont_nx;
    logic [CNT_W-1:0]  timer, timer_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [CNT_W-1:0]  hi, hi_nx;
    logic [CNT_W-1:0]  period_nx, high_time_nx;
    logic              period_valid_nx, timeout_nx;
    logic              timer_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WARMUP;
            warm_cnt     <= '0;
            cont_r       <= 1'b0;
            timer        <= '0;
            cnt          <= '0;
            hi           <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nx;
            warm_cnt     <= warm_nx;
            cont_r       <= cont_nx;
            timer        <= timer_nx;
            cnt          <= cnt_nx;
            hi           <= hi_nx;
            period       <= period_nx;
            high_time    <= high_time_nx;
            period_valid <= period_valid_nx;
            timeout      <= timeout_nx;
        end
    end

    assign timer_hit = (timer == TIMER_LAST);

    // An edge in the limit cycle takes priority, so a period of exactly TIMEOUT still measures.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx        = state;
        warm_nx         = warm_cnt;
        cont_nx         = cont_r;
        timer_nx        = timer;
        cnt_nx          = cnt;
        hi_nx           = hi;
        period_nx       = period;
        high_time_nx    = high_time;
        period_valid_nx = 1'b0;
        timeout_nx      = 1'b0;

        case (state)
            WARMUP: begin
                if (warm_cnt == WARM_LAST) state_nx = IDLE;
                else                       warm_nx  = warm_cnt + 1'b1;
            end
            IDLE: begin
                if (start) begin
                    state_nx = WAIT_EDGE;
                    cont_nx  = cont;
                    timer_nx = '0;
                end
            end
            WAIT_EDGE: begin
                if (rise) begin
                    state_nx = MEASURE;
                    cnt_nx   = CNT_ONE;
                    hi_nx    = CNT_ONE;
                    timer_nx = '0;
                end else if (timer_hit) begin
                    state_nx   = IDLE;
                    timeout_nx = 1'b1;
                end else begin
                    timer_nx = timer + CNT_ONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_nx       = cnt;
                    high_time_nx    = hi;
                    period_valid_nx = 1'b1;
                    cnt_nx          = CNT_ONE;
                    hi_nx           = CNT_ONE;
                    timer_nx        = '0;
                    if (!cont_r) state_nx = IDLE;
                end else if (timer_hit) begin
                    state_nx   = IDLE;
                    timeout_nx = 1'b1;
                end else begin
                    cnt_nx   = cnt + CNT_ONE;
                    hi_nx    = hi + CNT_W'(sync);
                    timer_nx = timer + CNT_ONE;
                end
            end
            default: state_nx = WARMUP;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with a scoreboard of expected result/timeout pulses.
module tb_clk_period_meter;

    localparam int CNT_W       = 32;
    localparam int TIMEOUT     = 100;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sig_in;
    logic             start;
    logic             cont;
    logic             busy;
    logic             period_valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             timeout;

    int errors = 0;
    int checks = 0;
    int unsigned ncyc = 0;
    int unsigned ref_c;

    typedef struct {
        bit               is_timeout;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high_time;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .start        (start),
        .cont         (cont),
        .busy         (busy),
        .period_valid (period_valid),
        .period       (period),
        .high_time    (high_time),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_evt(input bit to, input int p, input int h);
        exp_t e;
        e.is_timeout = to;
        e.period     = p;
        e.high_time  = h;
        sb_q.push_back(e);
    endtask

    // Every result or timeout pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (period_valid || timeout)) begin
            check("exclusive", period_valid & timeout, 1'b0);
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {period_valid, timeout}, 2'b00);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_kind", timeout, mon_e.is_timeout);
                check("sb_period", period, mon_e.period);
                check("sb_high_time", high_time, mon_e.high_time);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic c);
        start = 1'b1;
        cont  = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_wave(input int hi_c, input int lo_c, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            repeat (hi_c) @(negedge clk);
            sig_in = 1'b0;
            repeat (lo_c) @(negedge clk);
        end
    endtask

    task automatic wait_evt(input int max_c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(period_valid || timeout) && n < max_c);
        check("wait_bound", period_valid | timeout, 1'b1);
    endtask

    initial begin
        rst_n  = 1'b0;
        sig_in = 1'b1;
        start  = 1'b0;
        cont   = 1'b0;

        // Reset values with sig_in held high
        cycles(2);
        check("rst_busy", busy, 1'b1);
        check("rst_valid", period_valid, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_period", period, 0);
        check("rst_high_time", high_time, 0);

        // Warm-up: busy for SYNC_STAGES+1 cycles after release
        cycles(1);
        rst_n = 1'b1;
        check("warm_busy_0", busy, 1'b1);
        for (int i = 1; i <= SYNC_STAGES + 1; i++) begin
            @(negedge clk);
            check($sformatf("warm_busy_%0d", i), busy, (i <= SYNC_STAGES));
        end

        // No edge at all: timeout TIMEOUT cycles after busy rises
        expect_evt(1'b1, 0, 0);
        pulse_start(1'b0);
        ref_c = ncyc;
        check("t1_busy", busy, 1'b1);
        wait_evt(TIMEOUT + 20);
        check("t1_latency", ncyc - ref_c, TIMEOUT);
        check("t1_timeout", timeout, 1'b1);
        check("t1_busy_drop", busy, 1'b0);

        // 5 high / 5 low single shot
        sig_in = 1'b0;
        cycles(5);
        expect_evt(1'b0, 10, 5);
        pulse_start(1'b0);
        ref_c = ncyc;
        fork run_wave(5, 5, 3); join_none
        wait_evt(60);
        check("t2_latency", ncyc - ref_c, SYNC_STAGES + 1 + 10);
        check("t2_valid", period_valid, 1'b1);
        check("t2_busy_drop", busy, 1'b0);
        cycles(20);
        check("t2_idle", busy, 1'b0);

        // 3 high / 9 low continuous: four back-to-back results, then timeout
        for (int k = 0; k < 4; k++) expect_evt(1'b0, 12, 3);
        expect_evt(1'b1, 12, 3);
        pulse_start(1'b1);
        ref_c = ncyc;
        cont = 1'b0;
        fork run_wave(3, 9, 5); join_none
        wait_evt(40);
        check("t3_first_latency", ncyc - ref_c, SYNC_STAGES + 1 + 12);
        start = 1'b1;
        for (int k = 1; k < 4; k++) begin
            ref_c = ncyc;
            wait_evt(20);
            start = 1'b0;
            check($sformatf("t3_gap_%0d", k), ncyc - ref_c, 12);
            check($sformatf("t3_busy_%0d", k), busy, 1'b1);
        end
        ref_c = ncyc;
        wait_evt(TIMEOUT + 20);
        check("t3_to_latency", ncyc - ref_c, TIMEOUT);
        check("t3_to_busy", busy, 1'b0);

        // One rising edge then stuck low: timeout, period holds
        cycles(3);
        expect_evt(1'b1, 12, 3);
        pulse_start(1'b0);
        ref_c = ncyc;
        fork run_wave(2, 0, 1); join_none
        wait_evt(TIMEOUT + 20);
        check("t4_latency", ncyc - ref_c, SYNC_STAGES + 1 + TIMEOUT);
        check("t4_timeout", timeout, 1'b1);
        check("t4_period_hold", period, 12);
        check("t4_idle", busy, 1'b0);

        // Edge exactly at the timeout limit wins; start with cont while busy is ignored
        cycles(3);
        expect_evt(1'b0, TIMEOUT, TIMEOUT / 2);
        pulse_start(1'b0);
        ref_c = ncyc;
        fork run_wave(TIMEOUT / 2, TIMEOUT / 2, 2); join_none
        cycles(5);
        pulse_start(1'b1);
        cont = 1'b0;
        wait_evt(TIMEOUT + 20);
        check("t5_latency", ncyc - ref_c, SYNC_STAGES + 1 + TIMEOUT);
        check("t5_valid", period_valid, 1'b1);
        check("t5_no_timeout", timeout, 1'b0);
        cycles(TIMEOUT + 10);
        check("t5_idle", busy, 1'b0);

        // Asynchronous reset in the middle of a measurement
        cycles(3);
        pulse_start(1'b1);
        fork run_wave(5, 5, 1); join_none
        cycles(7);
        #2 rst_n = 1'b0;
        #1;
        check("t6_period_zero", period, 0);
        check("t6_high_zero", high_time, 0);
        check("t6_busy", busy, 1'b1);
        check("t6_valid", period_valid, 1'b0);
        check("t6_timeout", timeout, 1'b0);
        cycles(2);
        rst_n = 1'b1;
        cont  = 1'b0;
        cycles(SYNC_STAGES + 1);
        check("t6_warm_done", busy, 1'b0);
        expect_evt(1'b0, 10, 5);
        pulse_start(1'b0);
        ref_c = ncyc;
        fork run_wave(5, 5, 3); join_none
        wait_evt(60);
        check("t6_latency", ncyc - ref_c, SYNC_STAGES + 1 + 10);
        check("t6_valid_after", period_valid, 1'b1);
        cycles(25);

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
